// File: rtl/reg_wb.sv
// reg_wb: write-back stage and architectural register file for cpu15.
// Holds eight 16-bit registers and a per-register busy scoreboard so
// decode stalls instead of reading a register with an outstanding write.
//
// Ports:
//   CLK_WB          in   stage clock, rising edge
//   RESET           in   synchronous active-high reset
//   ISSUE_VALID     in   decode issues an instruction this cycle
//   ISSUE_N_SRC     in   [2:0] source register index
//   ISSUE_N_DST     in   [2:0] destination register index
//   WB_VALID        in   execute presents a result this cycle
//   WB_N_REG        in   [2:0] result destination index
//   WB_DATA         in   [15:0] result value
//   REG_0..REG_7    out  [15:0] registered register contents
//   BUSY            out  [7:0] outstanding-write scoreboard
//   STALL           out  combinational issue refusal
//   PENDING         out  [3:0] registered popcount of BUSY
//   WB_ERR          out  sticky, write-back to a non-busy register
module reg_wb (
  input  logic        CLK_WB,
  input  logic        RESET,
  input  logic        ISSUE_VALID,
  input  logic [2:0]  ISSUE_N_SRC,
  input  logic [2:0]  ISSUE_N_DST,
  input  logic        WB_VALID,
  input  logic [2:0]  WB_N_REG,
  input  logic [15:0] WB_DATA,
  output logic [15:0] REG_0,
  output logic [15:0] REG_1,
  output logic [15:0] REG_2,
  output logic [15:0] REG_3,
  output logic [15:0] REG_4,
  output logic [15:0] REG_5,
  output logic [15:0] REG_6,
  output logic [15:0] REG_7,
  output logic [7:0]  BUSY,
  output logic        STALL,
  output logic [3:0]  PENDING,
  output logic        WB_ERR
);

  localparam int unsigned NREG = 8;
  localparam int unsigned DW   = 16;
  localparam int unsigned PW   = 4;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy_next;
  logic [PW-1:0]   pending_next;
  logic            issue_ok;

  // Stall looks only at registered BUSY; a same-cycle write-back never bypasses.
  assign STALL    = ISSUE_VALID & (BUSY[ISSUE_N_SRC] | BUSY[ISSUE_N_DST]);
  assign issue_ok = ISSUE_VALID & ~STALL;

  // Next scoreboard: clear on write-back, then set on issue so set wins a collision.
  always_comb begin
    busy_next    = BUSY;
    pending_next = '0;
    if (WB_VALID) busy_next[WB_N_REG] = 1'b0;
    if (issue_ok) busy_next[ISSUE_N_DST] = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      pending_next = pending_next + PW'(busy_next[i]);
    end
  end

  // Register file, scoreboard, pending count and sticky error.
  always_ff @(posedge CLK_WB) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      BUSY    <= '0;
      PENDING <= '0;
      WB_ERR  <= 1'b0;
    end else begin
      if (WB_VALID) begin
        regs[WB_N_REG] <= WB_DATA;
        if (!BUSY[WB_N_REG]) WB_ERR <= 1'b1;
      end
      BUSY    <= busy_next;
      PENDING <= pending_next;
    end
  end

  assign REG_0 = regs[0];
  assign REG_1 = regs[1];
  assign REG_2 = regs[2];
  assign REG_3 = regs[3];
  assign REG_4 = regs[4];
  assign REG_5 = regs[5];
  assign REG_6 = regs[6];
  assign REG_7 = regs[7];

endmodule

// File: tb/tb_reg_wb.sv
// tb_reg_wb: scoreboard bench for reg_wb. Stimulus pushes expected values
// tagged with the cycle they must be observed in; a monitor pops and
// compares at each falling edge.
module tb_reg_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [2:0]  issue_src;
  logic [2:0]  issue_dst;
  logic        wb_valid;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [7:0]  busy;
  logic        stall;
  logic [3:0]  pending;
  logic        wb_err;

  localparam int SEL_BUSY = 8;
  localparam int SEL_PEND = 9;
  localparam int SEL_ERR  = 10;
  localparam int SEL_STALL = 11;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  reg_wb dut (
    .CLK_WB      (clk),
    .RESET       (rst),
    .ISSUE_VALID (issue_valid),
    .ISSUE_N_SRC (issue_src),
    .ISSUE_N_DST (issue_dst),
    .WB_VALID    (wb_valid),
    .WB_N_REG    (wb_reg),
    .WB_DATA     (wb_data),
    .REG_0       (r0),
    .REG_1       (r1),
    .REG_2       (r2),
    .REG_3       (r3),
    .REG_4       (r4),
    .REG_5       (r5),
    .REG_6       (r6),
    .REG_7       (r7),
    .BUSY        (busy),
    .STALL       (stall),
    .PENDING     (pending),
    .WB_ERR      (wb_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      0: return r0;
      1: return r1;
      2: return r2;
      3: return r3;
      4: return r4;
      5: return r5;
      6: return r6;
      7: return r7;
      SEL_BUSY: return 16'(busy);
      SEL_PEND: return 16'(pending);
      SEL_ERR:  return 16'(wb_err);
      default:  return 16'(stall);
    endcase
  endfunction

  // Insert keeping the queue ordered by observation cycle.
  task automatic push(input int c, input string nm, input int sel, input logic [15:0] v);
    exp_t e;
    int   idx;
    e.cyc = c; e.name = nm; e.sel = sel; e.exp = v;
    idx = sb.size();
    while (idx > 0 && sb[idx-1].cyc > c) idx--;
    sb.insert(idx, e);
  endtask

  task automatic exp_now(input string nm, input int sel, input logic [15:0] v);
    push(cyc, nm, sel, v);
  endtask

  task automatic exp_next(input string nm, input int sel, input logic [15:0] v);
    push(cyc + 1, nm, sel, v);
  endtask

  // Monitor: compare every entry due in the current cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] a;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = actual(e.sel);
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s stale entry for cycle %0d seen at %0d", e.name, e.cyc, cyc);
      end else if (a !== e.exp) begin
        errors++;
        $display("FAIL %s cycle %0d got %h want %h", e.name, cyc, a, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; issue_valid = 1'b0; wb_valid = 1'b0;
    issue_src = 3'd0; issue_dst = 3'd0; wb_reg = 3'd0; wb_data = 16'h0;
  endtask

  task automatic issue(input logic [2:0] s, input logic [2:0] d);
    issue_valid = 1'b1; issue_src = s; issue_dst = d;
  endtask

  task automatic wb(input logic [2:0] n, input logic [15:0] v);
    wb_valid = 1'b1; wb_reg = n; wb_data = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    #1;
    // Reset overrides a simultaneous write-back.
    rst = 1'b1;
    wb(3'd3, 16'hFFFF);
    tick();
    exp_now("rst_reg3", 3, 16'h0000);
    exp_now("rst_busy", SEL_BUSY, 16'h00);
    exp_now("rst_pend", SEL_PEND, 16'h0);
    exp_now("rst_err",  SEL_ERR,  16'h0);
    idle();

    // Issue dst2 then write it back.
    issue(3'd5, 3'd2);
    exp_now("iss_stall", SEL_STALL, 16'h0);
    exp_next("iss_busy", SEL_BUSY, 16'h04);
    exp_next("iss_pend", SEL_PEND, 16'h1);
    tick(); idle();
    wb(3'd2, 16'h1234);
    exp_next("wb_reg2", 2, 16'h1234);
    exp_next("wb_busy", SEL_BUSY, 16'h00);
    exp_next("wb_pend", SEL_PEND, 16'h0);
    exp_next("wb_err",  SEL_ERR,  16'h0);
    tick(); idle();

    // Stall on a busy source, held through the write-back cycle.
    issue(3'd0, 3'd4);
    exp_next("mk4_busy", SEL_BUSY, 16'h10);
    tick(); idle();
    issue(3'd4, 3'd1);
    exp_now("src_stall", SEL_STALL, 16'h1);
    exp_next("src_busy_held", SEL_BUSY, 16'h10);
    tick();
    wb(3'd4, 16'h0044);
    exp_now("src_stall_wbcyc", SEL_STALL, 16'h1);
    exp_next("src_reg4", 4, 16'h0044);
    exp_next("src_busy_wb", SEL_BUSY, 16'h00);
    tick();
    wb_valid = 1'b0;
    exp_now("src_stall_rel", SEL_STALL, 16'h0);
    exp_next("src_busy_acc", SEL_BUSY, 16'h02);
    exp_next("src_pend_acc", SEL_PEND, 16'h1);
    tick(); idle();
    wb(3'd1, 16'h1111);
    exp_next("src_clean", SEL_BUSY, 16'h00);
    tick(); idle();

    // Collision with dst busy: issue stalls, write-back clears.
    issue(3'd0, 3'd6);
    tick(); idle();
    issue(3'd0, 3'd6);
    wb(3'd6, 16'hABCD);
    exp_now("col1_stall", SEL_STALL, 16'h1);
    exp_next("col1_reg6", 6, 16'hABCD);
    exp_next("col1_busy", SEL_BUSY, 16'h00);
    exp_next("col1_err",  SEL_ERR,  16'h0);
    tick(); idle();

    // Write-back to a non-busy register sets the sticky error.
    wb(3'd7, 16'h0042);
    exp_next("err_reg7", 7, 16'h0042);
    exp_next("err_set", SEL_ERR, 16'h1);
    tick(); idle();
    issue(3'd3, 3'd3);
    tick(); idle();
    wb(3'd3, 16'h3333);
    exp_next("err_sticky", SEL_ERR, 16'h1);
    exp_next("err_reg3", 3, 16'h3333);
    exp_next("err_busy", SEL_BUSY, 16'h00);
    tick(); idle();

    // Collision with dst free: data written and busy set wins.
    issue(3'd6, 3'd6);
    wb(3'd6, 16'h5555);
    exp_now("col2_stall", SEL_STALL, 16'h0);
    exp_next("col2_reg6", 6, 16'h5555);
    exp_next("col2_busy", SEL_BUSY, 16'h40);
    exp_next("col2_pend", SEL_PEND, 16'h1);
    exp_next("col2_err",  SEL_ERR,  16'h1);
    tick(); idle();

    // Reset mid-operation discards busy bits; later write-back errors.
    rst = 1'b1;
    exp_next("mrst_busy", SEL_BUSY, 16'h00);
    exp_next("mrst_pend", SEL_PEND, 16'h0);
    exp_next("mrst_err",  SEL_ERR,  16'h0);
    exp_next("mrst_reg6", 6, 16'h0000);
    tick(); idle();
    wb(3'd6, 16'h0606);
    exp_next("mrst_wb_err", SEL_ERR, 16'h1);
    exp_next("mrst_wb_reg6", 6, 16'h0606);
    tick(); idle();
    rst = 1'b1;
    tick(); idle();

    // Fill all eight registers on consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      issue(3'(i), 3'(i));
      exp_now($sformatf("fill%0d_stall", i), SEL_STALL, 16'h0);
      exp_next($sformatf("fill%0d_busy", i), SEL_BUSY, 16'((1 << (i + 1)) - 1));
      exp_next($sformatf("fill%0d_pend", i), SEL_PEND, 16'(i + 1));
      tick();
    end
    issue(3'd0, 3'd0);
    exp_now("full_stall0", SEL_STALL, 16'h1);
    exp_next("full_busy", SEL_BUSY, 16'hFF);
    tick();
    issue(3'd3, 3'd5);
    exp_now("full_stall35", SEL_STALL, 16'h1);
    exp_next("full_pend", SEL_PEND, 16'h8);
    tick(); idle();
    exp_now("noissue_stall", SEL_STALL, 16'h0);
    tick();
    tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain %0d entries left want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
